gc_refresh_scheduler: RTL

Refresh scheduler for the gain-cell DRAM array. It shares the single array port between user accesses and periodic refresh sweeps over all rows. A written-row bitmap records rows written by the user since the last sweep, and the sweep skips those rows. A defer counter stops user traffic from starving refresh.

---
 rtl/gc_refresh_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gc_refresh_scheduler.sv
// Refresh scheduler for the gain-cell DRAM array.
// Arbitrates the single array port between user accesses and periodic
// refresh sweeps. Rows written since the last sweep are skipped, and a
// defer counter bounds how long a pending refresh yields to the user.
// Optional macro REF_STATS_EN adds a per-sweep skipped-row counter.
module gc_refresh_scheduler #(
    parameter int ADDR_W     = 7,
    parameter int ROWS       = 128,
    parameter int REF_PERIOD = 1024,
    parameter int MAX_DEFER  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              user_req,
    input  logic              user_we,
    input  logic [ADDR_W-1:0] user_addr,
    output logic              user_gnt,
    output logic              ref_en,
    output logic [ADDR_W-1:0] ref_addr,
    output logic              ref_skipped,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              overrun,
    output logic [ADDR_W:0]   skip_count
);

    localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int DW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
    localparam logic [TW-1:0]     TMAX     = TW'(REF_PERIOD - 1);
    localparam logic [DW-1:0]     DMAX     = DW'(MAX_DEFER);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W:0]   ROWS_W   = (ADDR_W + 1)'(ROWS);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DW-1:0]     defer_q, defer_d;
    logic [ROWS-1:0]   written_q, written_d;
    logic              overrun_q, overrun_d;
    logic              done_q, done_d;

    logic              tick;
    logic              gnt_c, ref_en_c, skip_c, advance;
    logic [ADDR_W-1:0] ref_addr_c;

    // Next-state, arbitration and bitmap update for the current cycle
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        defer_d    = defer_q;
        written_d  = written_q;
        overrun_d  = overrun_q;
        done_d     = 1'b0;
        gnt_c      = 1'b0;
        ref_en_c   = 1'b0;
        ref_addr_c = '0;
        skip_c     = 1'b0;
        advance    = 1'b0;

        tick    = (timer_q == TMAX);
        timer_d = tick ? '0 : timer_q + TW'(1);

        case (state_q)
            IDLE: begin
                gnt_c = user_req;
                if (tick) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                    defer_d = '0;
                end
            end
            SWEEP: begin
                // A tick here cannot restart the sweep; it only flags the overrun.
                if (tick) overrun_d = 1'b1;
                if (written_q[ptr_q]) begin
                    skip_c             = 1'b1;
                    gnt_c              = user_req;
                    written_d[ptr_q]   = 1'b0;
                    advance            = 1'b1;
                end else if (user_req && (defer_q < DMAX)) begin
                    gnt_c   = 1'b1;
                    defer_d = defer_q + DW'(1);
                end else begin
                    ref_en_c   = 1'b1;
                    ref_addr_c = ptr_q;
                    defer_d    = '0;
                    advance    = 1'b1;
                end
                if (advance) begin
                    if (ptr_q == LAST_ROW) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the skip clear so a same-cycle write keeps the bit set.
        if (gnt_c && user_we && ({1'b0, user_addr} < ROWS_W))
            written_d[user_addr] = 1'b1;
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ptr_q     <= '0;
            defer_q   <= '0;
            written_q <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ptr_q     <= ptr_d;
            defer_q   <= defer_d;
            written_q <= written_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

`ifdef REF_STATS_EN
    logic [ADDR_W:0] skip_acc_q, skip_acc_d;
    logic [ADDR_W:0] skip_cnt_q, skip_cnt_d;

    // Count skips within a sweep; publish the total on the sweep_done edge
    always_comb begin
        skip_acc_d = skip_acc_q;
        skip_cnt_d = skip_cnt_q;
        if (state_q == IDLE && tick) skip_acc_d = '0;
        else if (skip_c)             skip_acc_d = skip_acc_q + (ADDR_W + 1)'(1);
        if (done_d) skip_cnt_d = skip_acc_q + (ADDR_W + 1)'(skip_c);
    end

    // Skip statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_acc_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            skip_acc_q <= skip_acc_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign skip_count = rst ? '0 : skip_cnt_q;
`else
    assign skip_count = '0;
`endif

    // Every output reads 0 while reset is held, including the registered ones.
    assign user_gnt    = gnt_c & ~rst;
    assign ref_en      = ref_en_c & ~rst;
    assign ref_addr    = rst ? '0 : ref_addr_c;
    assign ref_skipped = skip_c & ~rst;
    assign sweep_busy  = (state_q == SWEEP) & ~rst;
    assign sweep_done  = done_q & ~rst;
    assign overrun     = overrun_q & ~rst;

endmodule
